// File: rtl/receiver_pkg.sv
// Shared constants, FSM state type and count helper for the receiver frame sequencer.
package receiver_pkg;

    localparam int unsigned NUM_RX_MAX       = 8;
    localparam int unsigned IQ_WIDTH_DEFAULT = 24;
    localparam int unsigned CNT_W            = 4;
    localparam int unsigned IDX_W            = $clog2(NUM_RX_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } seq_state_e;

    // Effective receiver count: 0 behaves as 1, anything above the build size saturates.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] req,
                                                     input logic [CNT_W-1:0] max_n);
        if (req == '0) return CNT_W'(1);
        if (req > max_n) return max_n;
        return req;
    endfunction

endpackage

// File: rtl/rx_frame_sequencer_if.sv
// Valid/ready sample stream leaving the frame sequencer.
interface rx_frame_sequencer_if
    import receiver_pkg::*;
#(
    parameter int unsigned IQ_WIDTH = IQ_WIDTH_DEFAULT
);
    logic                out_valid;
    logic                out_ready;
    logic [IQ_WIDTH-1:0] out_data_I;
    logic [IQ_WIDTH-1:0] out_data_Q;
    logic [IDX_W-1:0]    out_rx;
    logic                out_last;

    modport master (
        output out_valid, out_data_I, out_data_Q, out_rx, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data_I, out_data_Q, out_rx, out_last,
        output out_ready
    );
endinterface

// File: rtl/rx_sample_slot.sv
// One receiver slot: holding register for the latest I/Q sample, pending and sticky overrun flags.
module rx_sample_slot #(
    parameter int unsigned IQ_WIDTH = 24
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                strobe,
    input  logic [IQ_WIDTH-1:0] data_I,
    input  logic [IQ_WIDTH-1:0] data_Q,
    input  logic                drain,
    input  logic                overrun_clr,
    output logic [IQ_WIDTH-1:0] sample_I,
    output logic [IQ_WIDTH-1:0] sample_Q,
    output logic                pending,
    output logic                overrun
);

    // A strobe always wins over a drain; overrun only when the old sample was never taken.
    always_ff @(posedge clock) begin
        if (reset) begin
            sample_I <= '0;
            sample_Q <= '0;
            pending  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (strobe) begin
                sample_I <= data_I;
                sample_Q <= data_Q;
            end

            if (strobe)
                pending <= 1'b1;
            else if (drain)
                pending <= 1'b0;

            if (strobe && pending && !drain)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/rx_frame_sequencer.sv
// Collects one sample per active receiver slot and emits them as a back-to-back frame
// on a valid/ready stream, slot 0 first, with out_last on the final active slot.
module rx_frame_sequencer
    import receiver_pkg::*;
#(
    parameter int unsigned NUM_RX   = 4,
    parameter int unsigned IQ_WIDTH = IQ_WIDTH_DEFAULT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_RX-1:0]          rx_strobe,
    input  logic [NUM_RX*IQ_WIDTH-1:0] rx_data_I,
    input  logic [NUM_RX*IQ_WIDTH-1:0] rx_data_Q,
    input  logic [CNT_W-1:0]           num_rx,
    rx_frame_sequencer_if.master       out_if,
    output logic [NUM_RX-1:0]          overrun,
    input  logic                       overrun_clr
);

    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(NUM_RX);

    logic [IQ_WIDTH-1:0] slot_I [NUM_RX];
    logic [IQ_WIDTH-1:0] slot_Q [NUM_RX];
    logic [NUM_RX-1:0]   pending;
    logic [NUM_RX-1:0]   drain;
    logic [NUM_RX-1:0]   act_mask;

    seq_state_e          state_q, state_d;
    logic [CNT_W-1:0]    n_q, n_d, n_req;
    logic [IDX_W-1:0]    idx_q, idx_d, last_idx, sel;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic [IQ_WIDTH-1:0] data_I_q, data_I_d, data_Q_q, data_Q_d;
    logic [IQ_WIDTH-1:0] sel_I, sel_Q;
    logic                handshake;
    logic                all_pend;

    assign handshake = valid_q && out_if.out_ready;

    for (genvar g = 0; g < int'(NUM_RX); g++) begin : g_slot
        assign drain[g] = handshake && (idx_q == IDX_W'(g));

        rx_sample_slot #(.IQ_WIDTH(IQ_WIDTH)) u_slot (
            .clock       (clock),
            .reset       (reset),
            .strobe      (rx_strobe[g]),
            .data_I      (rx_data_I[g*IQ_WIDTH +: IQ_WIDTH]),
            .data_Q      (rx_data_Q[g*IQ_WIDTH +: IQ_WIDTH]),
            .drain       (drain[g]),
            .overrun_clr (overrun_clr),
            .sample_I    (slot_I[g]),
            .sample_Q    (slot_Q[g]),
            .pending     (pending[g]),
            .overrun     (overrun[g])
        );
    end

    // Frame start condition uses the live count; the same value is latched when leaving IDLE.
    assign n_req = clamp_count(num_rx, MAX_N);

    always_comb begin
        act_mask = '0;
        for (int i = 0; i < int'(NUM_RX); i++)
            act_mask[i] = (CNT_W'(i) < n_req);
    end

    assign all_pend = &(pending | ~act_mask);
    assign last_idx = IDX_W'(n_q - CNT_W'(1));
    assign sel      = (state_q == ST_SEND) ? IDX_W'(idx_q + IDX_W'(1)) : '0;

    always_comb begin
        sel_I = '0;
        sel_Q = '0;
        for (int i = 0; i < int'(NUM_RX); i++) begin
            if (IDX_W'(i) == sel) begin
                sel_I = slot_I[i];
                sel_Q = slot_Q[i];
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            n_q      <= CNT_W'(1);
            idx_q    <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            data_I_q <= '0;
            data_Q_q <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            data_I_q <= data_I_d;
            data_Q_q <= data_Q_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (all_pend) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_SEND;
            ST_SEND: if (handshake && (idx_q == last_idx)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the presented sample; without a handshake everything holds.
    always_comb begin
        n_d      = n_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        last_d   = last_q;
        data_I_d = data_I_q;
        data_Q_d = data_Q_q;
        case (state_q)
            ST_IDLE: n_d = n_req;
            ST_LOAD: begin
                idx_d    = '0;
                valid_d  = 1'b1;
                last_d   = (last_idx == '0);
                data_I_d = sel_I;
                data_Q_d = sel_Q;
            end
            ST_SEND: begin
                if (handshake) begin
                    if (idx_q != last_idx) begin
                        idx_d    = sel;
                        valid_d  = 1'b1;
                        last_d   = (sel == last_idx);
                        data_I_d = sel_I;
                        data_Q_d = sel_Q;
                    end else begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    assign out_if.out_valid  = valid_q;
    assign out_if.out_last   = last_q;
    assign out_if.out_rx     = idx_q;
    assign out_if.out_data_I = data_I_q;
    assign out_if.out_data_Q = data_Q_q;

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Scoreboard bench for rx_frame_sequencer: expected samples queued at strobe time, checked on handshake.
module tb_rx_frame_sequencer;

    localparam int unsigned NRX = 4;
    localparam int unsigned W   = 24;

    typedef struct packed {
        logic [2:0]   rx;
        logic         last;
        logic [W-1:0] i;
        logic [W-1:0] q;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset;
    logic [NRX-1:0]   rx_strobe;
    logic [NRX*W-1:0] rx_data_I;
    logic [NRX*W-1:0] rx_data_Q;
    logic [3:0]       num_rx;
    logic [NRX-1:0]   overrun;
    logic             overrun_clr;

    rx_frame_sequencer_if #(.IQ_WIDTH(W)) ob ();

    rx_frame_sequencer #(.NUM_RX(NRX), .IQ_WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_strobe   (rx_strobe),
        .rx_data_I   (rx_data_I),
        .rx_data_Q   (rx_data_Q),
        .num_rx      (num_rx),
        .out_if      (ob),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clock = ~clock;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    logic        hold_prev = 1'b0;
    logic [52:0] prev_bus = '0;
    wire  [52:0] bus_now = {ob.out_valid, ob.out_rx, ob.out_last, ob.out_data_I, ob.out_data_Q};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: stalled outputs must hold, accepted samples must match the scoreboard.
    always @(negedge clock) begin
        if (reset) begin
            hold_prev <= 1'b0;
        end else begin
            if (hold_prev) check("hold", 64'(bus_now), 64'(prev_bus));
            if (ob.out_valid && ob.out_ready) begin
                check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("out_rx", 64'(ob.out_rx), 64'(e.rx));
                    check("out_last", 64'(ob.out_last), 64'(e.last));
                    check("out_data_I", 64'(ob.out_data_I), 64'(e.i));
                    check("out_data_Q", 64'(ob.out_data_Q), 64'(e.q));
                end
            end
            hold_prev <= ob.out_valid && !ob.out_ready;
            prev_bus  <= bus_now;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_slot(input int s, input logic [W-1:0] vi, input logic [W-1:0] vq);
        rx_data_I[s*W +: W] = vi;
        rx_data_Q[s*W +: W] = vq;
    endtask

    task automatic strobe(input logic [NRX-1:0] m);
        rx_strobe = m;
        tick();
        rx_strobe = '0;
    endtask

    // Slot s carries I = base+s+1, Q = -(base+s+1); slots below n_act are expected out.
    task automatic load_frame(input logic [NRX-1:0] m, input int n_act, input int base);
        for (int s = 0; s < int'(NRX); s++)
            set_slot(s, W'(base + s + 1), W'(-(base + s + 1)));
        for (int s = 0; s < n_act; s++)
            sb.push_back('{rx: 3'(s), last: (s == n_act - 1), i: W'(base + s + 1), q: W'(-(base + s + 1))});
        strobe(m);
    endtask

    task automatic wait_drain(input string tag);
        int k;
        for (k = 0; k < 60; k++) begin
            if (sb.size() == 0 && !ob.out_valid) break;
            tick();
        end
        check(tag, 64'(k < 60), 64'd1);
    endtask

    task automatic wait_rx(input string tag, input logic [2:0] rx);
        int k;
        for (k = 0; k < 30; k++) begin
            if (ob.out_valid && ob.out_rx == rx) break;
            tick();
        end
        check(tag, 64'(k < 30), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        reset        = 1'b1;
        rx_strobe    = '0;
        rx_data_I    = '0;
        rx_data_Q    = '0;
        num_rx       = 4'd4;
        overrun_clr  = 1'b0;
        ob.out_ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", 64'(ob.out_valid), 64'd0);
        check("rst_last", 64'(ob.out_last), 64'd0);
        check("rst_rx", 64'(ob.out_rx), 64'd0);
        check("rst_data", 64'({ob.out_data_I, ob.out_data_Q}), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        reset = 1'b0;
        tick();

        // Basic frame: valid three cycles after the strobe cycle, then four back-to-back samples.
        load_frame(4'hF, 4, 0);
        for (k = 0; k < 10; k++) begin
            @(negedge clock);
            if (ob.out_valid) break;
        end
        check("latency", 64'(k), 64'd2);
        for (int j = 0; j < 4; j++) begin
            check("burst_valid", 64'(ob.out_valid), 64'd1);
            @(negedge clock);
        end
        check("burst_end", 64'(ob.out_valid), 64'd0);
        tick();
        wait_drain("t1_drain");

        // Backpressure mid-frame for five cycles.
        load_frame(4'hF, 4, 10);
        wait_rx("t2_reach", 3'd1);
        ob.out_ready = 1'b0;
        repeat (5) tick();
        ob.out_ready = 1'b1;
        wait_drain("t2_drain");

        // Overwrite slot 2 before it drains: newer value emitted, overrun flagged.
        ob.out_ready = 1'b0;
        for (int s = 0; s < int'(NRX); s++) begin
            set_slot(s, W'(21 + s), W'(-(21 + s)));
            if (s == 2) sb.push_back('{rx: 3'd2, last: 1'b0, i: W'(99), q: W'(-99)});
            else        sb.push_back('{rx: 3'(s), last: (s == 3), i: W'(21 + s), q: W'(-(21 + s))});
        end
        strobe(4'hF);
        set_slot(2, W'(99), W'(-99));
        strobe(4'b0100);
        check("ovr_set", 64'(overrun), 64'b0100);
        tick();
        ob.out_ready = 1'b1;
        wait_drain("t3_drain");
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("ovr_clr", 64'(overrun), 64'd0);

        // Count change mid-frame only affects the following frame.
        load_frame(4'hF, 4, 30);
        wait_rx("t4_reach", 3'd0);
        num_rx = 4'd2;
        wait_drain("t4a_drain");
        load_frame(4'b0011, 2, 40);
        wait_drain("t4b_drain");

        // Inactive slot still flags overrun but never starts a frame.
        set_slot(3, W'(7), W'(-7));
        strobe(4'b1000);
        strobe(4'b1000);
        check("ovr_inactive", 64'(overrun), 64'b1000);
        repeat (3) tick();
        check("inactive_quiet", 64'(ob.out_valid), 64'd0);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("ovr_clr2", 64'(overrun), 64'd0);

        // Zero count behaves as single-slot frames.
        num_rx = 4'd0;
        for (int r = 0; r < 2; r++) begin
            load_frame(4'b0001, 1, 50 + r * 5);
            wait_drain("t6_drain");
        end

        // Reset mid-frame at slot 2 abandons the rest.
        num_rx = 4'd4;
        load_frame(4'hF, 4, 60);
        wait_rx("t7_reach", 3'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        check("rst_mid_valid", 64'(ob.out_valid), 64'd0);
        check("rst_mid_rx", 64'(ob.out_rx), 64'd0);
        check("rst_mid_last", 64'(ob.out_last), 64'd0);
        check("rst_mid_ovr", 64'(overrun), 64'd0);
        for (int j = 0; j < 6; j++) begin
            tick();
            check("rst_mid_idle", 64'(ob.out_valid), 64'd0);
        end
        load_frame(4'hF, 4, 70);
        wait_drain("t7_recover");

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
